display_scheduler: RTL and testbench

Sequencing and scan controller in front of the seven-segment decoder. It steps the calculator display through operand 1, operand 2, wait-for-ALU and result views. It owns the decimal/hex mode toggle and formats the selected value into per-digit codes. It time-multiplexes those codes across the four anodes, so the downstream decoder is purely combinational.

---
 rtl/display_scheduler.sv | 128 ++++++++++++
 tb/tb_display_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// View sequencer, decimal/hex formatter and four-digit anode scanner for the
// calculator display; feeds a purely combinational seven-segment decoder.
module display_scheduler #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] operand1,
  input  logic [3:0] operand2,
  input  logic [4:0] result,
  input  logic       result_valid,
  input  logic       next_btn,
  input  logic       mode_change,
  output logic [3:0] an,
  output logic [4:0] digit,
  output logic [1:0] view,
  output logic       hex_mode
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [4:0]  BLANK = 5'd16;
  localparam logic [4:0]  MINUS = 5'd17;

  typedef enum logic [1:0] {
    OP1      = 2'd0,
    OP2      = 2'd1,
    WAIT_ALU = 2'd2,
    RESULT   = 2'd3
  } state_t;

  state_t           state;
  logic             nb_prev;
  logic             mc_prev;
  logic [4:0]       res_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic             nb_rise;
  logic             mc_rise;
  logic [4:0]       d [4];
  logic [5:0]       res_ext;
  logic [5:0]       mag;
  logic [3:0]       op_v;
  logic             two_digit;

  assign nb_rise = next_btn & ~nb_prev;
  assign mc_rise = mode_change & ~mc_prev;
  assign view    = state;

  // Digit set for the current view; d[0] is the rightmost position.
  always_comb begin
    for (int i = 0; i < 4; i++) d[i] = BLANK;
    res_ext   = {res_q[4], res_q};
    mag       = res_q[4] ? (~res_ext + 6'd1) : res_ext;
    op_v      = (state == OP1) ? operand1 : operand2;
    two_digit = 1'b0;
    case (state)
      OP1, OP2: begin
        if (hex_mode || op_v < 4'd10) begin
          d[0] = {1'b0, op_v};
        end else begin
          d[1] = 5'd1;
          d[0] = {1'b0, 4'(op_v - 4'd10)};
        end
      end
      WAIT_ALU: begin
        for (int i = 0; i < 4; i++) d[i] = MINUS;
      end
      default: begin
        if (hex_mode) begin
          two_digit = mag[4];
          d[0]      = {1'b0, mag[3:0]};
        end else begin
          two_digit = (mag >= 6'd10);
          d[0]      = two_digit ? 5'(mag - 6'd10) : mag[4:0];
        end
        // |result| never exceeds 16, so any tens/sixteens digit is 1.
        if (two_digit) d[1] = 5'd1;
        if (res_q[4]) begin
          if (two_digit) d[2] = MINUS;
          else           d[1] = MINUS;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= OP1;
      nb_prev  <= 1'b1;
      mc_prev  <= 1'b1;
      hex_mode <= 1'b0;
      res_q    <= 5'd0;
      cnt      <= '0;
      idx      <= 2'd0;
      an       <= 4'b1111;
      digit    <= BLANK;
    end else begin
      nb_prev <= next_btn;
      mc_prev <= mode_change;
      if (mc_rise) hex_mode <= ~hex_mode;

      case (state)
        OP1:      if (nb_rise) state <= OP2;
        OP2:      if (nb_rise) state <= WAIT_ALU;
        WAIT_ALU: begin
          if (result_valid) begin
            state <= RESULT;
            res_q <= result;
          end
        end
        RESULT:   if (nb_rise) state <= OP1;
        default:  state <= OP1;
      endcase

      // Scan runs free of view/mode changes.
      if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      an    <= ~(4'b0001 << idx);
      digit <= d[idx];
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: randomized and directed stimulus
// compared against a behavioural model of views, number formatting and scan.
module tb_display_scheduler;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] operand1;
  logic [3:0] operand2;
  logic [4:0] result;
  logic       result_valid;
  logic       next_btn;
  logic       mode_change;
  logic [3:0] an;
  logic [4:0] digit;
  logic [1:0] view;
  logic       hex_mode;

  always #5 clk = ~clk;

  display_scheduler #(.REFRESH_DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .operand1     (operand1),
    .operand2     (operand2),
    .result       (result),
    .result_valid (result_valid),
    .next_btn     (next_btn),
    .mode_change  (mode_change),
    .an           (an),
    .digit        (digit),
    .view         (view),
    .hex_mode     (hex_mode)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_view, m_res, m_k;
  bit m_hex, m_nbp, m_mcp;
  logic [3:0] exp_an;
  logic [4:0] exp_digit;
  logic [1:0] exp_view;
  logic       exp_hex;

  // Glyph at position pos: write the value out in base 10/16, then a minus sign.
  function automatic int model_digit(int v, bit hx, int r, int a, int b, int pos);
    int val, m, base;
    int q[$];
    if (v == 2) return 17;
    val  = (v == 0) ? a : (v == 1) ? b : r;
    m    = (val < 0) ? -val : val;
    base = hx ? 16 : 10;
    do begin
      q.push_back(m % base);
      m = m / base;
    end while (m > 0);
    if (val < 0) q.push_back(17);
    return (pos < q.size()) ? q[pos] : 16;
  endfunction

  // One clock edge: predict outputs from pre-edge state, then advance the model.
  task automatic step();
    int slot;
    bit nr, mr;
    @(posedge clk);
    if (reset) begin
      m_view = 0; m_hex = 0; m_res = 0; m_nbp = 1; m_mcp = 1; m_k = 0;
      exp_an = 4'hF;
      exp_digit = 5'd16;
    end else begin
      slot = (m_k / DIV) % 4;
      exp_an = 4'hF;
      exp_an[slot] = 1'b0;
      exp_digit = 5'(model_digit(m_view, m_hex, m_res, int'(operand1), int'(operand2), slot));
      m_k++;
      nr = next_btn && !m_nbp;
      mr = mode_change && !m_mcp;
      if (m_view == 2) begin
        if (result_valid) begin
          m_res  = $signed(result);
          m_view = 3;
        end
      end else if (nr) begin
        m_view = (m_view + 1) % 4;
      end
      if (mr) m_hex = !m_hex;
      m_nbp = next_btn;
      m_mcp = mode_change;
    end
    exp_view = 2'(m_view);
    exp_hex  = m_hex;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; next_btn = 1; mode_change = 1; result_valid = 1;
    operand1 = 4'($urandom); operand2 = 4'($urandom); result = 5'($urandom);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({an, digit, view, hex_mode} !== {4'b1111, 5'd16, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_values an=%b/1111 digit=%0d/16 view=%0d/0 hex=%0d/0", an, digit, view, hex_mode);
      end
    end
    reset = 0; result_valid = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++;
      if (view !== 2'd0 || {an, digit, hex_mode} !== {exp_an, exp_digit, exp_hex}) begin
        n_fail++;
        $display("FAIL held_button t=%0t an=%b/%b digit=%0d/%0d view=%0d/0 hex=%0d/%0d",
                 $time, an, exp_an, digit, exp_digit, view, hex_mode, exp_hex);
      end
    end
    next_btn = 0; mode_change = 0;
    step();
  endtask

  task automatic test_scan();
    reset = 1; operand1 = 4'd7;
    step();
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++;
      if ({an, digit, view, hex_mode} !== {exp_an, exp_digit, exp_view, exp_hex}) begin
        n_fail++;
        $display("FAIL scan i=%0d an=%b/%b digit=%0d/%0d view=%0d/%0d hex=%0d/%0d",
                 i, an, exp_an, digit, exp_digit, view, exp_view, hex_mode, exp_hex);
      end
      if (i == 0 || i == 4 || i == 16) begin
        n_tests++;
        if (an !== ((i == 4) ? 4'b1101 : 4'b1110) || digit !== ((i == 4) ? 5'd16 : 5'd7)) begin
          n_fail++;
          $display("FAIL scan_slot i=%0d an=%b digit=%0d", i, an, digit);
        end
      end
    end
  endtask

  task automatic test_mode();
    operand1 = 4'd12;
    for (int i = 0; i < 25; i++) begin
      mode_change = (i == 8);
      step();
      n_tests++;
      if ({an, digit, view, hex_mode} !== {exp_an, exp_digit, exp_view, exp_hex}) begin
        n_fail++;
        $display("FAIL mode i=%0d an=%b/%b digit=%0d/%0d view=%0d/%0d hex=%0d/%0d",
                 i, an, exp_an, digit, exp_digit, view, exp_view, hex_mode, exp_hex);
      end
    end
    mode_change = 0;
    n_tests++;
    if (hex_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_toggle hex=%0d expected 1", hex_mode);
    end
  endtask

  task automatic test_views();
    reset = 1;
    step();
    reset = 0;
    operand1 = 4'($urandom); operand2 = 4'($urandom); result = 5'd9;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 3; j++) begin
        result_valid = (j == 0 && p < 2);
        next_btn     = (j == 1);
        step();
        n_tests++;
        if ({an, digit, view, hex_mode} !== {exp_an, exp_digit, exp_view, exp_hex}) begin
          n_fail++;
          $display("FAIL views p=%0d j=%0d an=%b/%b digit=%0d/%0d view=%0d/%0d hex=%0d/%0d",
                   p, j, an, exp_an, digit, exp_digit, view, exp_view, hex_mode, exp_hex);
        end
      end
    end
    result_valid = 0; next_btn = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_tests++;
      if (view !== 2'd2 || digit !== 5'd17 || an !== exp_an) begin
        n_fail++;
        $display("FAIL wait_dashes i=%0d view=%0d/2 digit=%0d/17 an=%b/%b", i, view, digit, an, exp_an);
      end
    end
  endtask

  task automatic test_collision();
    result = 5'(-5); result_valid = 1; next_btn = 1;
    step();
    result_valid = 0; next_btn = 0; result = 5'($urandom);
    n_tests++;
    if (view !== 2'd3) begin
      n_fail++;
      $display("FAIL collision_view view=%0d expected 3", view);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      n_tests++;
      if ({an, digit, view, hex_mode} !== {exp_an, exp_digit, exp_view, exp_hex}) begin
        n_fail++;
        $display("FAIL collision i=%0d an=%b/%b digit=%0d/%0d view=%0d/%0d",
                 i, an, exp_an, digit, exp_digit, view, exp_view);
      end
    end
  endtask

  task automatic test_neg16();
    for (int i = 0; i < 48; i++) begin
      next_btn     = (i == 0 || i == 2 || i == 4);
      result       = (i == 6) ? 5'b10000 : 5'($urandom);
      result_valid = (i == 6);
      mode_change  = (i == 7 || i == 30);
      step();
      n_tests++;
      if ({an, digit, view, hex_mode} !== {exp_an, exp_digit, exp_view, exp_hex}) begin
        n_fail++;
        $display("FAIL neg16 i=%0d an=%b/%b digit=%0d/%0d view=%0d/%0d hex=%0d/%0d",
                 i, an, exp_an, digit, exp_digit, view, exp_view, hex_mode, exp_hex);
      end
    end
    next_btn = 0; result_valid = 0; mode_change = 0;
  endtask

  task automatic test_reset_mid();
    mode_change = 1;
    step();
    mode_change = 0;
    step();
    reset = 1; next_btn = 1; result_valid = 1; mode_change = 1;
    step();
    n_tests++;
    if ({an, digit, view, hex_mode} !== {4'b1111, 5'd16, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid an=%b/1111 digit=%0d/16 view=%0d/0 hex=%0d/0", an, digit, view, hex_mode);
    end
    reset = 0; next_btn = 0; result_valid = 0; mode_change = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) next_btn = ~next_btn;
      if ($urandom_range(0, 9) == 0) mode_change = ~mode_change;
      result_valid = ($urandom_range(0, 7) == 0);
      result       = 5'($urandom);
      if ($urandom_range(0, 5) == 0) operand1 = 4'($urandom);
      if ($urandom_range(0, 5) == 0) operand2 = 4'($urandom);
      step();
      n_tests++;
      if ({an, digit, view, hex_mode} !== {exp_an, exp_digit, exp_view, exp_hex}) begin
        n_fail++;
        $display("FAIL random i=%0d an=%b/%b digit=%0d/%0d view=%0d/%0d hex=%0d/%0d",
                 i, an, exp_an, digit, exp_digit, view, exp_view, hex_mode, exp_hex);
      end
    end
  endtask

  initial begin
    reset = 1; next_btn = 0; mode_change = 0; result_valid = 0;
    operand1 = 0; operand2 = 0; result = 0;
    test_reset();
    test_scan();
    test_mode();
    test_views();
    test_collision();
    test_neg16();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
